// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, controller states and
// the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    // High for an illegal size or an address not aligned to the access size.
    function automatic logic lsu_access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: sub-word extraction with sign/zero
// extension on loads, and sub-word insertion into a read word on stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half lanes of the memory word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane to a full load result.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{is_signed & half_s[15]}}, half_s};
            SZ_WORD: load_data = word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Overlay the low bits of the store data onto the addressed lane.
    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   store_word[7:0]   = wdata[7:0];
                    2'b01:   store_word[15:8]  = wdata[7:0];
                    2'b10:   store_word[23:16] = wdata[7:0];
                    2'b11:   store_word[31:24] = wdata[7:0];
                    default: store_word        = word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0]  = wdata[15:0];
                end
            end
            SZ_WORD: store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store controller driving a 64-word data memory. Sub-word stores are
// done as read-modify-write; misaligned or illegal requests never touch memory.
module data_mem_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_we2,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_r;
    lsu_state_e  state_nxt_s;
    logic        accept_s;
    logic        req_err_s;

    logic [1:0]  size_r;
    logic [1:0]  addr_lo_r;
    logic        signed_r;
    logic [31:0] wdata_r;

    logic        req_ready_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [5:0]  mem_address_r;
    logic [31:0] mem_write_data_r;
    logic        mem_we2_r;

    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    assign req_err_s = lsu_access_err(req_size, req_addr[1:0]);

    lsu_align u_align (
        .word       (mem_read_data),
        .addr_lo    (addr_lo_r),
        .size       (size_r),
        .is_signed  (signed_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .store_word (store_word_s)
    );

    // Next-state decode and request acceptance.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_err_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (!req_we) begin
                        state_nxt_s = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_MERGE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt_s = ST_RESP;
            ST_MERGE: state_nxt_s = ST_WRITE;
            ST_WRITE: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latches, response registers and memory-port drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_r           <= 2'b00;
            addr_lo_r        <= 2'b00;
            signed_r         <= 1'b0;
            wdata_r          <= 32'h0000_0000;
            req_ready_r      <= 1'b1;
            resp_valid_r     <= 1'b0;
            resp_err_r       <= 1'b0;
            resp_rdata_r     <= 32'h0000_0000;
            mem_address_r    <= 6'd0;
            mem_write_data_r <= 32'h0000_0000;
            mem_we2_r        <= 1'b0;
        end else begin
            // Status flags track the state being entered so they line up with it.
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            mem_we2_r    <= (state_nxt_s == ST_WRITE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        size_r       <= req_size;
                        addr_lo_r    <= req_addr[1:0];
                        signed_r     <= req_signed;
                        wdata_r      <= req_wdata;
                        resp_err_r   <= req_err_s;
                        resp_rdata_r <= 32'h0000_0000;
                        if (!req_err_s) begin
                            mem_address_r <= req_addr[7:2];
                        end
                        if (!req_err_s && req_we && (req_size == SZ_WORD)) begin
                            mem_write_data_r <= req_wdata;
                        end
                    end
                end
                ST_LOAD:  resp_rdata_r     <= load_data_s;
                ST_MERGE: mem_write_data_r <= store_word_s;
                default: begin
                end
            endcase
        end
    end

    assign req_ready      = req_ready_r;
    assign resp_valid     = resp_valid_r;
    assign resp_err       = resp_err_r;
    assign resp_rdata     = resp_rdata_r;
    assign mem_address    = mem_address_r;
    assign mem_write_data = mem_write_data_r;
    // Gating with reset keeps a reset that lands in WRITE from committing the store.
    assign mem_we2        = mem_we2_r & ~reset;

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store controller that acts as the initiator for the word-organised data memory (6-bit word address, 32-bit data, `we2` write strobe, combinational read). Accepts byte-addressed load/store requests from the CPU datapath over a valid/ready handshake and produces the memory port drive. Performs byte/halfword extraction with sign/zero extension and sub-word stores by read-modify-write. Flags misaligned and illegal-size accesses without touching memory.

## Interface
- No parameters. Memory geometry is fixed: 64 words, byte address bits [7:2] form the word index.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size, from `lsu_pkg`.
- `req_signed` in 1: sign-extend sub-word loads.
- `req_addr` in 8: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response available; held until accepted.
- `resp_ready` in 1: CPU accepts response.
- `resp_rdata` out 32: load result, 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal size.
- `mem_address` out 6: data memory word address.
- `mem_write_data` out 32: data memory write word.
- `mem_we2` out 1: data memory write enable.
- `mem_read_data` in 32: data memory read word, combinational from `mem_address`.

## Operation
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch all `req_*` fields. Error check: size 2'b11, half with addr[0]=1, or word with addr[1:0]!=0 sets err and goes to RESP. Otherwise load goes to LOAD, word store to WRITE, byte/half store to MERGE.
- LOAD: drive `mem_address`=addr[7:2]. Capture the lane selected by addr[1:0] (byte) or addr[1] (half), extended per `req_signed`; full word for size word. Next state RESP.
- MERGE: drive the address and capture the read word. Replace the addressed byte or half with the low bits of wdata and hold the result in the write buffer. Next state WRITE.
- WRITE: drive the address, `mem_write_data`=buffer, `mem_we2`=1 for exactly this cycle. Next state RESP.
- RESP: `resp_valid`=1, with `resp_rdata` and `resp_err` stable. Goes to IDLE in the cycle `resp_ready`=1.
- `mem_we2` is high only in WRITE and is forced 0 while `reset`=1.
- `mem_address` holds its last value outside LOAD/MERGE/WRITE. `mem_write_data` is driven only meaningfully in WRITE.
- Little-endian lanes: byte k is bits [8k+7:8k].

## Timing
- Request accepted on the rising edge where IDLE and `req_valid`=1.
- `resp_valid` rises this many edges after acceptance:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
- Back-to-back throughput: a new request is accepted no earlier than the edge after response acceptance. `req_ready` is 0 in every state except IDLE.
- Memory write commits on the edge ending WRITE. A load immediately following a store to the same word returns the new data.
- Reset values: state IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_address`=0, `mem_write_data`=0, `mem_we2`=0. `req_ready`=1 from the first cycle after reset deasserts.
- Reset mid-operation aborts with no response. Reset during WRITE suppresses the write.
- `resp_ready` held high in RESP: one-cycle response, then IDLE.

## Structure
- `lsu_pkg`: size enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, 2'b11 illegal), state enum, and a misalignment-check function.
- Sub-module `lsu_align`: purely combinational.
  - Load side: extract/extend from word, addr[1:0], size and signed.
  - Store side: merge sub-word into word.
- The top level holds the FSM and registers.

## Test plan
- Word store 0xDEADBEEF at addr 0x10, then word load at 0x10: `mem_we2` high one cycle with `mem_address`=4; load returns 0xDEADBEEF, err=0, 2-edge latency each.
- Byte store 0x7F at addr 0x11 over word 0xDEADBEEF: MERGE reads 0xDEADBEEF and WRITE writes 0xDEAD7FEF. Then signed byte load at 0x13 returns 0xFFFFFFDE; unsigned returns 0x000000DE.
- Half store 0x8001 at addr 0x22, then signed half load at 0x22 returns 0xFFFF8001; unsigned half load at 0x20 returns the original low half.
- Word load at 0x05 and half store at 0x07: response after 1 edge with err=1, rdata=0, `mem_we2` never asserted.
- `resp_ready` held low 3 cycles in RESP: `resp_valid` and `resp_rdata` stable, `req_ready`=0 throughout. Next request accepted the edge after `resp_ready`.
- Reset asserted during WRITE of a sub-word store: no write occurs, all outputs return to reset values next cycle, `req_ready`=1 after reset release.
